enable_table_loader: RTL

- Writer side of the RAM/bus enable table. It fetches one packed configuration image from a byte-wide config memory (flash-shadow BRAM) and unpacks it into table_write_addr/table_val/table_we write strobes.
- Runs at boot and on every configuration change. busy is used upstream to hold the CPU (mreq gating) while the table is rewritten.

---
 rtl/ramenable_pkg.sv | 31 +++
 rtl/enable_table_loader_entry_unpacker.sv | 52 +++++
 rtl/enable_table_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ramenable_pkg.sv
// Shared definitions for the RAM/bus enable table: entry layout, table
// geometry and the loader state encoding.
package ramenable_pkg;

    // One table entry is {ram_en, bus_en}; the table consumer uses the
    // same bit positions.
    localparam int ENTRY_BITS       = 2;
    localparam int RAM_EN_BIT       = 1;
    localparam int BUS_EN_BIT       = 0;

    // 512 entries: rwbar + 8 page bits.
    localparam int TABLE_ADDR_BITS  = 9;
    localparam int CONFIG_BITS      = 6;

    // A packed image is 128 bytes of 4 entries each.
    localparam int BYTES_PER_IMAGE  = 128;
    localparam int BYTE_IDX_BITS    = $clog2(BYTES_PER_IMAGE);
    localparam int ENTRIES_PER_BYTE = 8 / ENTRY_BITS;
    localparam int K_BITS           = $clog2(ENTRIES_PER_BYTE);

    localparam int TIMEOUT_CYCLES   = 255;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/enable_table_loader_entry_unpacker.sv
// entry_unpacker: holds one image byte and presents its four 2-bit entries
// LSB pair first, with the entry index k and a flag on the last entry.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture byte_in and restart at k=0
//   byte_in    : image byte from config memory
//   advance    : move to the next entry
//   entry      : current entry value
//   k          : current entry index within the byte
//   last       : current entry is the fourth of the byte
module entry_unpacker
    import ramenable_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [7:0]            byte_in,
    input  logic                  advance,
    output logic [ENTRY_BITS-1:0] entry,
    output logic [K_BITS-1:0]     k,
    output logic                  last
);

    logic [7:0]        shreg_q, shreg_d;
    logic [K_BITS-1:0] k_q, k_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            k_q     <= '0;
        end else begin
            shreg_q <= shreg_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        k_d     = k_q;
        if (load) begin
            shreg_d = byte_in;
            k_d     = '0;
        end else if (advance) begin
            shreg_d = shreg_q >> ENTRY_BITS;
            k_d     = k_q + K_BITS'(1);
        end
    end

    assign entry = shreg_q[ENTRY_BITS-1:0];
    assign k     = k_q;
    assign last  = (k_q == K_BITS'(ENTRIES_PER_BYTE - 1));

endmodule

// File: rtl/enable_table_loader.sv
// enable_table_loader: fetches one packed 128-byte image from config memory
// and writes its 512 two-bit entries into the RAM/bus enable table.
//   fpga_clk, reset   : clock, asynchronous active-high reset
//   start, abort      : begin loading config_sel / terminate a load
//   config_sel        : image index, latched on an accepted start
//   mem_addr, mem_rd  : byte address and one-cycle read request
//   mem_data/valid    : read data and its strobe
//   table_we/val/     : table write strobe, entry value and index
//   table_write_addr
//   busy, done, error : load in progress, completion pulse, sticky timeout
module enable_table_loader #(
    parameter int TABLE_ADDR_BITS = ramenable_pkg::TABLE_ADDR_BITS,
    parameter int ENTRY_BITS      = ramenable_pkg::ENTRY_BITS,
    parameter int CONFIG_BITS     = ramenable_pkg::CONFIG_BITS,
    parameter int TIMEOUT_CYCLES  = ramenable_pkg::TIMEOUT_CYCLES
) (
    input  logic                       fpga_clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CONFIG_BITS-1:0]     config_sel,
    output logic [CONFIG_BITS+7-1:0]   mem_addr,
    output logic                       mem_rd,
    input  logic [7:0]                 mem_data,
    input  logic                       mem_valid,
    output logic                       table_we,
    output logic [ENTRY_BITS-1:0]      table_val,
    output logic [TABLE_ADDR_BITS-1:0] table_write_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    import ramenable_pkg::state_t;
    import ramenable_pkg::IDLE;
    import ramenable_pkg::REQ;
    import ramenable_pkg::WAIT;
    import ramenable_pkg::WRITE;
    import ramenable_pkg::DONE;
    import ramenable_pkg::BYTES_PER_IMAGE;
    import ramenable_pkg::BYTE_IDX_BITS;
    import ramenable_pkg::K_BITS;

    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BYTE_IDX_BITS-1:0] LAST_BYTE =
        BYTE_IDX_BITS'(BYTES_PER_IMAGE - 1);

    // The write address is a plain {byte_idx, k} concatenation, so the
    // table geometry is fixed by the image layout.
    generate
        if (TABLE_ADDR_BITS != BYTE_IDX_BITS + K_BITS) begin : g_bad_addr
            $error("TABLE_ADDR_BITS must equal 9");
        end
        if (ENTRY_BITS != 2) begin : g_bad_entry
            $error("ENTRY_BITS must equal 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_to
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    state_t                     state_q, state_d;
    logic [CONFIG_BITS-1:0]     cfg_q, cfg_d;
    logic [BYTE_IDX_BITS-1:0]   byte_idx_q, byte_idx_d;
    logic [TO_BITS-1:0]         to_cnt_q, to_cnt_d;
    logic                       error_q, error_d;
    logic [TABLE_ADDR_BITS-1:0] waddr_q, waddr_d;

    logic                       start_ok;
    logic                       aborting;
    logic                       timeout_hit;
    logic                       load;
    logic                       advance;
    logic [ENTRY_BITS-1:0]      entry;
    logic [K_BITS-1:0]          k;
    logic                       last;
    logic [TABLE_ADDR_BITS-1:0] wr_addr;

    assign aborting    = abort && (state_q != IDLE);
    assign start_ok    = (state_q == IDLE) && start && !abort;
    assign timeout_hit = (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1));
    assign load        = (state_q == WAIT) && mem_valid && !abort;
    assign advance     = (state_q == WRITE) && !abort;
    assign wr_addr     = TABLE_ADDR_BITS'({byte_idx_q, k});

    entry_unpacker u_unpack (
        .clk     (fpga_clk),
        .rst     (reset),
        .load    (load),
        .byte_in (mem_data),
        .advance (advance),
        .entry   (entry),
        .k       (k),
        .last    (last)
    );

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            byte_idx_q <= '0;
            to_cnt_q   <= '0;
            error_q    <= 1'b0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            byte_idx_q <= byte_idx_d;
            to_cnt_q   <= to_cnt_d;
            error_q    <= error_d;
            waddr_q    <= waddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (start_ok) state_d = REQ;
                REQ:   state_d = WAIT;
                WAIT: begin
                    if (mem_valid)        state_d = WRITE;
                    else if (timeout_hit) state_d = IDLE;
                end
                WRITE: begin
                    if (last) begin
                        state_d = (byte_idx_q == LAST_BYTE) ? DONE : REQ;
                    end
                end
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_d      = cfg_q;
        byte_idx_d = byte_idx_q;
        to_cnt_d   = to_cnt_q;
        error_d    = error_q;
        waddr_d    = waddr_q;
        if (start_ok) begin
            cfg_d      = config_sel;
            byte_idx_d = '0;
            error_d    = 1'b0;
        end
        if (!aborting) begin
            if (state_q == REQ) begin
                to_cnt_d = '0;
            end
            if (state_q == WAIT && !mem_valid) begin
                to_cnt_d = to_cnt_q + TO_BITS'(1);
                if (timeout_hit) error_d = 1'b1;
            end
            if (state_q == WRITE) begin
                // Remember the last written index so the address output
                // holds it once the load leaves WRITE.
                waddr_d = wr_addr;
                if (last && byte_idx_q != LAST_BYTE) begin
                    byte_idx_d = byte_idx_q + BYTE_IDX_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        mem_addr         = {cfg_q, byte_idx_q};
        mem_rd           = (state_q == REQ);
        table_we         = 1'b0;
        table_val        = '0;
        table_write_addr = waddr_q;
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        error            = error_q;
        if (state_q == WRITE) begin
            table_we         = 1'b1;
            table_val        = entry;
            table_write_addr = wr_addr;
        end
    end

endmodule
